// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid buffer and sync flush.
// Optional perf counters (stall/bubble) are built when PIPE_PERF_EN is defined.
module pipe_stage_skid #(
  parameter int unsigned PAYLOAD_W = 40,
  parameter bit          RST_CLEAR = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PAYLOAD_W-1:0] m_q, m_d;
  logic [PAYLOAD_W-1:0] s_q, s_d;
  logic                 in_ready_q;
  logic                 accept, deliver;

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != StEmpty);
  assign out_payload = m_q;
  assign occupancy   = state_q;
  assign accept      = in_valid & in_ready_q;
  assign deliver     = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          m_d     = in_payload;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && deliver) begin
          m_d = in_payload;
        end else if (accept) begin
          s_d     = in_payload;
          state_d = StTwo;
        end else if (deliver) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (deliver) begin
          m_d     = s_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // A same-cycle deliver has already been seen downstream; only held entries are killed.
    if (flush) begin
      state_d = StEmpty;
      if (RST_CLEAR) begin
        m_d = '0;
        s_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
      if (RST_CLEAR) begin
        m_q <= '0;
        s_q <= '0;
      end
    end else begin
      state_q    <= state_d;
      // Flopped from next state so in_ready never depends combinationally on out_ready.
      in_ready_q <= (state_d != StTwo);
      m_q        <= m_d;
      s_q        <= s_d;
    end
  end

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_q, bubble_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (!out_valid && (bubble_q != {CNT_W{1'b1}})) begin
        bubble_q <= bubble_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid against a queue-based reference model.
module tb_pipe_stage_skid;

  localparam int unsigned W     = 40;
  localparam int unsigned CW    = 4;
  localparam int unsigned CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_payload = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_payload;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;

  pipe_stage_skid #(
    .PAYLOAD_W (W),
    .RST_CLEAR (1'b1),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  (in_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload),
    .occupancy   (occupancy),
    .stall_cnt   (stall_cnt),
    .bubble_cnt  (bubble_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO of held payloads plus counters.
  logic [W-1:0] mq[$];
  bit           cleared;
  int unsigned  m_stall, m_bubble, n_deliv, dut_deliv;
  int unsigned  n_checks = 0;
  int unsigned  n_pass = 0;

  // Drives one cycle of inputs, advances the model, returns 1ns after the clock edge.
  task automatic drive_cycle(input logic v, input logic [W-1:0] p, input logic r,
                             input logic f, input logic rst);
    bit acc, del;
    reset = rst; flush = f; in_valid = v; in_payload = p; out_ready = r;
    acc = v && (mq.size() < 2);
    del = r && (mq.size() > 0);
    if (!rst && out_valid && r) dut_deliv++;
    if (rst) begin
      mq.delete(); cleared = 1; m_stall = 0; m_bubble = 0;
    end else begin
      if (mq.size() > 0 && !r && m_stall < CMAX) m_stall++;
      if (mq.size() == 0 && m_bubble < CMAX) m_bubble++;
      if (del) n_deliv++;
      if (f) begin
        mq.delete(); cleared = 1;
      end else begin
        if (del) void'(mq.pop_front());
        if (acc) begin mq.push_back(p); cleared = 0; end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, 40'hAA, 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b1, 40'hBB, 1'b0, 1'b0, 1'b1);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_checks++; if (occupancy !== 2'd0) $display("FAIL reset_occ got %0d want 0", occupancy); else n_pass++;
    n_checks++; if (out_payload !== '0) $display("FAIL reset_payload got %h want 0", out_payload); else n_pass++;
    n_checks++; if (stall_cnt !== '0 || bubble_cnt !== '0)
      $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, bubble_cnt); else n_pass++;
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) begin
      drive_cycle(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
      n_checks++; if (occupancy !== 2'd1) $display("FAIL stream_occ[%0d] got %0d want 1", i, occupancy); else n_pass++;
      n_checks++; if (out_payload !== W'(i)) $display("FAIL stream_payload[%0d] got %0d want %0d", i, out_payload, i); else n_pass++;
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL stream_drain got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, c;
    int unsigned d0;
    a = 40'hA0A0; b = 40'hB0B0; c = 40'hC0C0;
    d0 = dut_deliv;
    drive_cycle(1'b1, a, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, b, 1'b0, 1'b0, 1'b0);
    n_checks++; if (occupancy !== 2'd2) $display("FAIL bp_occ got %0d want 2", occupancy); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", in_ready); else n_pass++;
    drive_cycle(1'b1, c, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, c, 1'b0, 1'b0, 1'b0);
    n_checks++; if (out_payload !== a || occupancy !== 2'd2)
      $display("FAIL bp_hold got %h/%0d want %h/2", out_payload, occupancy, a); else n_pass++;
    drive_cycle(1'b1, c, 1'b1, 1'b0, 1'b0);
    n_checks++; if (out_payload !== b) $display("FAIL bp_second got %h want %h", out_payload, b); else n_pass++;
    drive_cycle(1'b1, c, 1'b1, 1'b0, 1'b0);
    n_checks++; if (out_payload !== c) $display("FAIL bp_third got %h want %h", out_payload, c); else n_pass++;
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b0 || dut_deliv - d0 != 3)
      $display("FAIL bp_count got %0d deliveries want 3", dut_deliv - d0); else n_pass++;
  endtask

  task automatic test_flush();
    logic [W-1:0] e;
    e = 40'hE0E0;
    drive_cycle(1'b1, 40'h1111, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 40'h2222, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 40'hDDDD, 1'b0, 1'b1, 1'b0);
    n_checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_state got occ=%0d ov=%b ir=%b want 0/0/1", occupancy, out_valid, in_ready);
    else n_pass++;
    n_checks++; if (out_payload !== '0) $display("FAIL flush_payload got %h want 0", out_payload); else n_pass++;
    drive_cycle(1'b1, e, 1'b1, 1'b0, 1'b0);
    n_checks++; if (out_payload !== e || occupancy !== 2'd1)
      $display("FAIL flush_next got %h/%0d want %h/1", out_payload, occupancy, e); else n_pass++;
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_flush_deliver();
    int unsigned d0;
    drive_cycle(1'b1, 40'hF00F, 1'b0, 1'b0, 1'b0);
    d0 = dut_deliv;
    drive_cycle(1'b1, 40'h6006, 1'b1, 1'b1, 1'b0);
    n_checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0)
      $display("FAIL flush_deliver_state got occ=%0d ov=%b want 0/0", occupancy, out_valid); else n_pass++;
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (dut_deliv - d0 != 1)
      $display("FAIL flush_deliver_count got %0d want 1", dut_deliv - d0); else n_pass++;
  endtask

  task automatic test_random();
    logic v, r, f;
    logic [W-1:0] p;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 31) == 0);
      p = {$urandom, $urandom};
      drive_cycle(v, p, r, f, 1'b0);
      n_checks++; if (occupancy !== 2'(mq.size()) || out_valid !== (mq.size() > 0) ||
                      in_ready !== (mq.size() < 2))
        $display("FAIL rand_ctrl[%0d] got occ=%0d ov=%b ir=%b want occ=%0d", i, occupancy,
                 out_valid, in_ready, mq.size());
      else n_pass++;
      if (mq.size() > 0) begin
        n_checks++; if (out_payload !== mq[0])
          $display("FAIL rand_payload[%0d] got %h want %h", i, out_payload, mq[0]); else n_pass++;
      end else if (cleared) begin
        n_checks++; if (out_payload !== '0)
          $display("FAIL rand_cleared[%0d] got %h want 0", i, out_payload); else n_pass++;
      end
`ifdef PIPE_PERF_EN
      n_checks++; if (stall_cnt !== CW'(m_stall) || bubble_cnt !== CW'(m_bubble))
        $display("FAIL rand_cnt[%0d] got %0d/%0d want %0d/%0d", i, stall_cnt, bubble_cnt,
                 m_stall, m_bubble);
      else n_pass++;
`endif
    end
  endtask

  task automatic test_perf();
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b1, 40'h77, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_PERF_EN
    n_checks++; if (stall_cnt !== 4'd15) $display("FAIL perf_stall got %0d want 15", stall_cnt); else n_pass++;
`else
    n_checks++; if (stall_cnt !== '0) $display("FAIL perf_stall_off got %0d want 0", stall_cnt); else n_pass++;
`endif
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
`ifdef PIPE_PERF_EN
    // One bubble from the load cycle after reset, plus the three empty cycles.
    n_checks++; if (bubble_cnt !== 4'd4) $display("FAIL perf_bubble got %0d want 4", bubble_cnt); else n_pass++;
    drive_cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (bubble_cnt !== 4'd5 || stall_cnt !== 4'd15)
      $display("FAIL perf_flush_keep got %0d/%0d want 15/5", stall_cnt, bubble_cnt); else n_pass++;
`else
    n_checks++; if (bubble_cnt !== '0) $display("FAIL perf_bubble_off got %0d want 0", bubble_cnt); else n_pass++;
`endif
  endtask

  initial begin
    mq.delete(); cleared = 1; m_stall = 0; m_bubble = 0; n_deliv = 0; dut_deliv = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_flush_deliver();
    test_random();
    test_perf();
    test_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
